// File: rtl/fifo2apb_master.sv
// fifo2apb_master: pops commands from the async command FIFO and runs each one
// as an APB3 transfer. The completion status and read data are pushed to the
// async response FIFO.
//
// Build option: define APB_TIMEOUT_EN to abort an ACCESS phase that waits
// longer than TIMEOUT_CYCLES. The aborted transfer returns {timeout=1, error=1}.
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for a command while the response FIFO has space
// SETUP  | APB setup phase; the command FIFO pop strobe is high
// ACCESS | APB access phase; waiting for pready (or for the timeout)
module fifo2apb_master #(
   parameter int ADDR_WIDTH     = 16,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                             pclk,
   input  logic                             preset_n,
   input  logic                             cmd_read_empty,
   input  logic [ADDR_WIDTH+DATA_WIDTH:0]   cmd_read_data,
   output logic                             cmd_read_inc,
   input  logic                             rsp_write_full,
   output logic [DATA_WIDTH+1:0]            rsp_write_data,
   output logic                             rsp_write_inc,
   output logic [ADDR_WIDTH-1:0]            paddr,
   output logic                             psel,
   output logic                             penable,
   output logic                             pwrite,
   output logic [DATA_WIDTH-1:0]            pwdata,
   input  logic [DATA_WIDTH-1:0]            prdata,
   input  logic                             pready,
   input  logic                             pslverr,
   output logic                             busy
);

   localparam int CMD_W = ADDR_WIDTH + DATA_WIDTH + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'b001,
      SETUP  = 3'b010,
      ACCESS = 3'b100
   } state_t;

   state_t state;
   logic   start;

   if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   // A transfer only starts when its response is guaranteed a slot.
   assign start = !cmd_read_empty && !rsp_write_full;

`ifdef APB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt;
   logic            to_hit;

   // This wait cycle is the one that brings the count up to the limit.
   assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));
`endif

   // Transfer sequencing with every output registered.
   always_ff @(posedge pclk or negedge preset_n) begin
      if (!preset_n) begin
         state          <= IDLE;
         psel           <= 1'b0;
         penable        <= 1'b0;
         pwrite         <= 1'b0;
         paddr          <= '0;
         pwdata         <= '0;
         cmd_read_inc   <= 1'b0;
         rsp_write_inc  <= 1'b0;
         rsp_write_data <= '0;
         busy           <= 1'b0;
`ifdef APB_TIMEOUT_EN
         to_cnt         <= '0;
`endif
      end else begin
         cmd_read_inc  <= 1'b0;
         rsp_write_inc <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  pwrite       <= cmd_read_data[CMD_W-1];
                  paddr        <= cmd_read_data[CMD_W-2:DATA_WIDTH];
                  pwdata       <= cmd_read_data[DATA_WIDTH-1:0];
                  psel         <= 1'b1;
                  cmd_read_inc <= 1'b1;
                  busy         <= 1'b1;
                  state        <= SETUP;
               end
            end
            SETUP: begin
               penable <= 1'b1;
               state   <= ACCESS;
`ifdef APB_TIMEOUT_EN
               to_cnt  <= '0;
`endif
            end
            ACCESS: begin
               if (pready) begin
                  rsp_write_data <= {1'b0, pslverr,
                                     pwrite ? {DATA_WIDTH{1'b0}} : prdata};
                  rsp_write_inc  <= 1'b1;
                  psel           <= 1'b0;
                  penable        <= 1'b0;
                  pwrite         <= 1'b0;
                  paddr          <= '0;
                  pwdata         <= '0;
                  busy           <= 1'b0;
                  state          <= IDLE;
               end
`ifdef APB_TIMEOUT_EN
               else if (to_hit) begin
                  rsp_write_data <= {2'b11, {DATA_WIDTH{1'b0}}};
                  rsp_write_inc  <= 1'b1;
                  psel           <= 1'b0;
                  penable        <= 1'b0;
                  pwrite         <= 1'b0;
                  paddr          <= '0;
                  pwdata         <= '0;
                  busy           <= 1'b0;
                  state          <= IDLE;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
               end
`endif
            end
            default: begin
               psel    <= 1'b0;
               penable <= 1'b0;
               busy    <= 1'b0;
               state   <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/fifo2apb_master.md
# fifo2apb_master

APB initiator on the `pclk` side of the serial-link transceiver. It pops transaction commands from an asynchronous command FIFO and executes each as an APB3 transfer. Each completion is returned to an asynchronous response FIFO. It is the counterpart of the APB-to-FIFO slave bridge: it lets the link-side logic read and write APB registers through the FIFO pair.

## Interface
Parameters:
- `ADDR_WIDTH`, 16, APB address width.
- `DATA_WIDTH`, 32, APB data width.
- `TIMEOUT_CYCLES`, 16, maximum ACCESS cycles before abort. Used only with `APB_TIMEOUT_EN`.

Ports:
- `pclk`  in  1  APB clock; all logic is on its rising edge.
- `preset_n`  in  1  reset, asynchronous, active-low.
- `cmd_read_empty`  in  1  command FIFO empty.
- `cmd_read_data`  in  49  show-ahead head entry: [48]=write, [47:32]=addr, [31:0]=wdata.
- `cmd_read_inc`  out  1  one-cycle pop strobe.
- `rsp_write_full`  in  1  response FIFO full.
- `rsp_write_data`  out  34  [33]=timeout, [32]=error, [31:0]=rdata (0 for writes).
- `rsp_write_inc`  out  1  one-cycle push strobe.
- `paddr`  out  16  APB address.
- `psel`  out  1  APB select.
- `penable`  out  1  APB enable.
- `pwrite`  out  1  APB direction.
- `pwdata`  out  32  APB write data.
- `prdata`  in  32  APB read data.
- `pready`  in  1  APB ready.
- `pslverr`  in  1  APB slave error.
- `busy`  out  1  high in SETUP and ACCESS.

## Operation
- State machine, one-hot: IDLE, SETUP, ACCESS.
- **IDLE → SETUP:** taken when `!cmd_read_empty && !rsp_write_full`. On that edge:
  - latch `pwrite`, `paddr` and `pwdata` from `cmd_read_data`;
  - set `psel`=1 and `cmd_read_inc`=1.
- **IDLE, start condition false:** stay in IDLE; all APB outputs and strobes are 0.
- **SETUP → ACCESS:** unconditional. Set `penable`=1 and `cmd_read_inc`=0.
- **ACCESS with `pready`=1:**
  - clear `psel` and `penable`;
  - set `rsp_write_data` = {1'b0, `pslverr`, `pwrite` ? 32'd0 : `prdata`} and `rsp_write_inc`=1;
  - go to IDLE.
- **ACCESS with `pready`=0:** hold all APB outputs stable.
- `rsp_write_inc` and `cmd_read_inc` are each exactly one cycle wide.
- Exactly one pop and exactly one push per transaction.
- `rsp_write_data` holds its value until the next push. It is 0 after reset.
- Response-FIFO space is checked before the transfer starts, so a push never overflows.
- `pwdata` is driven from the command on reads as well; slaves ignore it.
- `busy` = SETUP | ACCESS.
- **Reset mid-operation:**
  - all outputs go to 0 immediately and the state goes to IDLE;
  - the in-flight transaction is dropped: no response is pushed;
  - the popped command is lost.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Minimum transaction: 3 cycles (IDLE, SETUP, ACCESS with `pready`=1). Back-to-back throughput is one transfer per 3 cycles.
- Cycle T is the IDLE cycle in which the start condition is sampled:
  - T+1: `psel`=1, `cmd_read_inc`=1.
  - T+2: `penable`=1.
  - T+2+N: first cycle with `pready` sampled high, after N wait states.
  - T+3+N: `psel`=`penable`=0, `rsp_write_inc`=1, state IDLE.
- The FIFO pops at the end of T+1, so IDLE always sees the updated head entry.
- A `rsp_write_full` rise during SETUP or ACCESS has no effect on the current transfer.

## Configuration
- Macro: `APB_TIMEOUT_EN`.
- **Defined:** an internal counter clears on entry to ACCESS and increments on each ACCESS cycle with `pready`=0.
  - When the counter reaches `TIMEOUT_CYCLES`, the transfer is aborted on that edge: `psel`=`penable`=0, response {1'b1, 1'b1, 32'd0} is pushed, state goes to IDLE.
  - If `pready` rises on the same edge that the limit is reached, `pready` wins and a normal response is pushed.
- **Undefined:** there is no counter, ACCESS waits on `pready` indefinitely, and `rsp_write_data[33]` is constant 0.

## Test plan
- **Write, zero wait:** push {1, 0x0002, 0xA5A5_0001}, `pready` tied 1 → `psel` at T+1, `penable` at T+2, one `cmd_read_inc` pulse, response 0x0_0000_0000 pushed at T+3, `busy` low at T+3.
- **Read, 3 wait states:** push {0, 0x0003, x}, `prdata`=0x1234_5678, `pready` low for 3 ACCESS cycles → `penable` high for 4 cycles with stable `paddr`, response 0x0_1234_5678.
- **Slave error:** read with `pslverr`=1 and `prdata`=0xDEAD_BEEF on the ready cycle → response 0x1_DEAD_BEEF.
- **Back-pressure:** 2 commands queued with `rsp_write_full`=1 → `psel`=0 and no pops; release full → 2 transfers spaced 3 cycles apart, 2 pops, 2 pushes.
- **Timeout:** `pready` stuck 0.
  - With `APB_TIMEOUT_EN`: abort after 16 ACCESS cycles, response 0x3_0000_0000.
  - Without it: the transfer is still in ACCESS after 100 cycles, with no push.
- **Reset in ACCESS:** assert `preset_n`=0 during a wait state → all outputs 0 immediately; after release, state is IDLE, no response is pushed, and the next queued command runs normally.
